// File: rtl/system_boton_in_capture.sv
// Avalon-MM input PIO: synchronises buttons, optionally debounces (SYSTEM_BOTON_IN_DEBOUNCE_EN),
// latches selected edges into a W1C capture register and raises a maskable level IRQ.
module system_boton_in_capture #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("system_boton_in_capture: illegal parameter value");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d1_q;
  logic [WIDTH-1:0] rise, fall, edge_evt;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;
  logic [31:0]      unused_wdata;

  assign unused_wdata = writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef SYSTEM_BOTON_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [WIDTH-1:0] stable_q;

  // A bit only follows sync after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (sync[b] == stable_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == CNT_LAST) begin
          stable_q[b] <= sync[b];
          cnt_q[b]    <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + CW'(1);
        end
      end
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync;
`endif

  assign rise = stable & ~stable_d1_q;
  assign fall = ~stable & stable_d1_q;

  always_comb begin
    edge_evt = rise | fall;
    case (EDGE_TYPE)
      0:       edge_evt = rise;
      1:       edge_evt = fall;
      default: edge_evt = rise | fall;
    endcase
  end

  assign wr_en  = chipselect & ~write_n;
  assign mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  assign w1c    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  // New edges are OR'd in after the clear so a coincident edge is never lost.
  assign cap_d  = (cap_q & ~w1c) | edge_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d1_q <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
    end else begin
      stable_d1_q <= stable;
      mask_q      <= mask_d;
      cap_q       <= cap_d;
    end
  end

  assign irq = |(cap_q & mask_q);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = 32'(stable);
      2'd2:    readdata = 32'(mask_q);
      2'd3:    readdata = 32'(cap_q);
      default: readdata = '0;
    endcase
  end

endmodule
